// File: rtl/fmcw_pkg.sv
// Shared encodings for the FFT output framer: FIFO entry kinds, word tags and sync word.
package fmcw_pkg;

    // Kind field carried with every FIFO entry
    localparam logic [1:0] KIND_MID   = 2'b00;
    localparam logic [1:0] KIND_FIRST = 2'b01;
    localparam logic [1:0] KIND_LAST  = 2'b10;
    localparam logic [1:0] KIND_ABORT = 2'b11;

    // Top nibble of every emitted word
    localparam logic [3:0] TAG_HDR  = 4'hA;
    localparam logic [3:0] TAG_DATA = 4'h5;
    localparam logic [3:0] TAG_TRL  = 4'hC;

    localparam logic [31:0] SYNC_WORD = 32'h5A5AA5A5;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ACTIVE,
        C_DROP
    } cap_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_DATA,
        O_TRL
    } out_state_t;

    function automatic word_t make_header(input logic [15:0] frame_num,
                                          input logic [31:0] sync);
        return {TAG_HDR, 12'h000, frame_num, sync};
    endfunction

    function automatic word_t make_trailer(input logic [10:0] count, input logic err,
                                           input logic [15:0] frame_num,
                                           input logic [31:0] sync);
        return {TAG_TRL, count, err, frame_num, sync};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 62,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_framer.sv
// Frames the unstallable FFT output into header/data/trailer 64-bit words for the ft245 port.
module fft_framer #(
    parameter int unsigned  FFT_N      = 1024,
    parameter int unsigned  N_WIDTH    = $clog2(FFT_N),
    parameter int unsigned  DATA_WIDTH = 25,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter logic [31:0]  SYNC_WORD  = fmcw_pkg::SYNC_WORD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fft_valid_i,
    input  logic [N_WIDTH-1:0]    fft_ctr_i,
    input  logic [DATA_WIDTH-1:0] fft_re_i,
    input  logic [DATA_WIDTH-1:0] fft_im_i,
    input  logic                  fifo_full_i,
    output logic                  wren_o,
    output logic [63:0]           wrdata_o,
    output logic [15:0]           frame_num_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_cnt_o
);
    import fmcw_pkg::*;

    localparam int unsigned ENTRY_W = 2 + N_WIDTH + 2 * DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [N_WIDTH-1:0] LAST_CTR = N_WIDTH'(FFT_N - 1);

    // FIFO interface
    logic                  push;
    logic [1:0]            push_kind;
    logic [ENTRY_W-1:0]    push_data;
    logic                  pop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;

    logic [1:0]            head_kind;
    logic [N_WIDTH-1:0]    head_ctr;
    logic [DATA_WIDTH-1:0] head_re;
    logic [DATA_WIDTH-1:0] head_im;

    // Capture side
    cap_state_t            cap_state;
    cap_state_t            cap_next;
    logic                  abort_evt;
    logic                  sample_room;
    logic                  abort_room;
    logic                  is_first_ctr;
    logic                  is_last_ctr;

    // Output side
    out_state_t            out_state;
    logic                  out_valid;
    word_t                 out_word;
    logic [10:0]           word_cnt;
    logic                  take;
    word_t                 data_word;

    assign push_data = {push_kind, fft_ctr_i, fft_re_i, fft_im_i};
    assign {head_kind, head_ctr, head_re, head_im} = fifo_head;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // One slot is kept back so an abort marker always fits behind a blocked sample
    assign sample_room  = (fifo_count < CNT_W'(FIFO_DEPTH - 1));
    assign abort_room   = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign is_first_ctr = (fft_ctr_i == '0);
    assign is_last_ctr  = (fft_ctr_i == LAST_CTR);

    // Capture decode: what to push this cycle and where the capture FSM goes next
    always_comb begin
        push      = 1'b0;
        push_kind = KIND_MID;
        abort_evt = 1'b0;
        cap_next  = cap_state;
        case (cap_state)
            C_IDLE: begin
                if (fft_valid_i && is_first_ctr) begin
                    if (sample_room) begin
                        push      = 1'b1;
                        push_kind = KIND_FIRST;
                        cap_next  = C_ACTIVE;
                    end else begin
                        // No room even to start: the frame is lost before it begins
                        abort_evt = 1'b1;
                        cap_next  = C_DROP;
                    end
                end
            end
            C_ACTIVE: begin
                if (fft_valid_i) begin
                    if (is_first_ctr || !sample_room) begin
                        abort_evt = 1'b1;
                        cap_next  = C_DROP;
                    end else begin
                        push = 1'b1;
                        if (is_last_ctr) begin
                            push_kind = KIND_LAST;
                            cap_next  = C_IDLE;
                        end
                    end
                end
            end
            C_DROP: begin
                if (fft_valid_i && is_last_ctr) begin
                    cap_next = C_IDLE;
                end
            end
            default: cap_next = C_IDLE;
        endcase
        if (abort_evt) begin
            push      = abort_room;
            push_kind = KIND_ABORT;
        end
    end

    // Capture FSM state and abort bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_state  <= C_IDLE;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            cap_state <= cap_next;
            if (abort_evt) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) begin
                    drop_cnt_o <= drop_cnt_o + 16'd1;
                end
            end
        end
    end

    // The register reloads whenever it is empty or being drained this cycle
    assign wren_o    = out_valid && !fifo_full_i;
    assign take      = !out_valid || wren_o;
    assign wrdata_o  = out_word;
    assign data_word = {TAG_DATA, head_ctr, head_re, head_im};

    // Pop decode: header load leaves the first sample in place for the data phase
    always_comb begin
        pop = 1'b0;
        if (take && !fifo_empty) begin
            case (out_state)
                O_IDLE:  pop = (head_kind != KIND_FIRST);
                O_DATA:  pop = 1'b1;
                default: pop = 1'b0;
            endcase
        end
    end

    // Output FSM and output word register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_state   <= O_IDLE;
            out_valid   <= 1'b0;
            out_word    <= '0;
            word_cnt    <= '0;
            frame_num_o <= '0;
        end else begin
            if (wren_o) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                case (out_state)
                    O_IDLE: begin
                        if (!fifo_empty && head_kind == KIND_FIRST) begin
                            out_word  <= make_header(frame_num_o, SYNC_WORD);
                            out_valid <= 1'b1;
                            word_cnt  <= '0;
                            out_state <= O_DATA;
                        end
                    end
                    O_DATA: begin
                        if (!fifo_empty) begin
                            out_valid <= 1'b1;
                            if (head_kind == KIND_ABORT) begin
                                out_word    <= make_trailer(word_cnt, 1'b1, frame_num_o,
                                                            SYNC_WORD);
                                frame_num_o <= frame_num_o + 16'd1;
                                out_state   <= O_IDLE;
                            end else begin
                                out_word <= data_word;
                                word_cnt <= word_cnt + 11'd1;
                                if (head_kind == KIND_LAST) begin
                                    out_state <= O_TRL;
                                end
                            end
                        end
                    end
                    O_TRL: begin
                        out_word    <= make_trailer(word_cnt, 1'b0, frame_num_o, SYNC_WORD);
                        out_valid   <= 1'b1;
                        frame_num_o <= frame_num_o + 16'd1;
                        out_state   <= O_IDLE;
                    end
                    default: out_state <= O_IDLE;
                endcase
            end
        end
    end

endmodule
